awb_gain_calc: RTL
==================

Name: awb_gain_calc

Overview:
- Gray-world auto-white-balance statistics and gain generator.
- Taps the debayered RGB pixel stream, either before or after the gain stage, and accumulates per-channel sums over each frame.
- At each frame boundary it computes red and blue gains relative to green, using a serial divider.
- Drives the red/green/blue gain inputs of the post-debayer gain stage, closing the white-balance loop.

Parameters:
- SUBPIXEL_WIDTH, 8, bits per colour component.
- PIXEL_CNT, 2, pixels per clock on the stream bus.
- ACC_WIDTH, 32, width of each per-channel frame accumulator.

Ports:
- i_pclk  input  1  pixel clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_enable  input  1  1 = update gains each frame; 0 = hold current gains.
- i_vs  input  1  vertical sync; rising edge marks frame boundary.
- i_de  input  1  data enable.
- i_valid  input  1  pixel valid.
- i_r  input  SUBPIXEL_WIDTH*PIXEL_CNT  red, lane k at [k*SUBPIXEL_WIDTH +: SUBPIXEL_WIDTH].
- i_g  input  SUBPIXEL_WIDTH*PIXEL_CNT  green, same packing.
- i_b  input  SUBPIXEL_WIDTH*PIXEL_CNT  blue, same packing.
- o_red_gain  output  10  red gain, 256 = 1.0, range 0..1023.
- o_green_gain  output  10  green gain, constant 256.
- o_blue_gain  output  10  blue gain, 256 = 1.0.
- o_gain_valid  output  1  one-cycle pulse when gains update.
- o_busy  output  1  high while the divider is running.

Behaviour:
- Reset: all three gains = 256; o_gain_valid = 0; o_busy = 0; accumulators, latched sums and vs delay register = 0; state = IDLE.
- Frame edge: i_vs sampled high while the registered previous i_vs is 0.
- Accumulate:
  - On every edge with i_de && i_valid, add all PIXEL_CNT lanes of each channel to acc_r/acc_g/acc_b.
  - Each accumulator saturates at all-ones and never wraps.
- On a frame edge:
  - Accumulators are cleared.
  - If the current cycle also carries qualified pixels, those pixels seed the new accumulators.
  - If state = IDLE and i_enable = 1: pre-clear accumulator values go to sum_r/sum_g/sum_b; state -> DIV_R.
  - Otherwise the frame's statistics are discarded (frame skipped).
- State machine IDLE -> DIV_R -> DIV_B -> UPDATE -> IDLE:
  - DIV_R: 10 cycles, computes q_r = floor((sum_g<<8)/sum_r).
  - DIV_B: 10 cycles, computes q_b = floor((sum_g<<8)/sum_b).
  - UPDATE: 1 cycle; registers the gains and pulses o_gain_valid.
- Divider:
  - Restoring, one quotient bit per cycle, bits 9 down to 0.
  - Remainder width ACC_WIDTH+18.
  - For bit i: if rem >= den<<i then rem -= den<<i and q[i] = 1.
- Divider boundary cases, checked on DIV entry:
  - sum_g<<8 >= den<<10 -> result 1023 (clamp).
  - den == 0 or sum_g == 0 -> result 256 (unity).
- Latency: detecting edge = edge 0; gains change and o_gain_valid = 1 after edge 21; o_busy = 1 after edges 1..21 inclusive.
- o_green_gain is always 256.
- Accumulation continues in all states; divider operands are the latched sums only.
- i_enable deasserted mid-computation: the computation completes and updates the gains.
- Reset mid-computation: immediate return to reset values; no o_gain_valid pulse.

Optional Feature:
- Macro: AWB_SAT_EXCLUDE_EN.
- Defined: a lane is excluded from all three accumulators when any of its R, G or B equals all-ones.
- Not defined: every qualified lane is accumulated.

Test Plan:
- Flat grey frame (R=G=B=100, 64x4 lanes), then vs rise -> o_gain_valid after edge 21; all gains = 256.
- R=50, G=100, B=200 flat frame -> o_red_gain = 512, o_blue_gain = 128, o_green_gain = 256.
- R=10, G=200 -> red quotient 5120 clamps to 1023; R=0 everywhere -> o_red_gain = 256.
- Second vs rise while o_busy = 1 -> no extra computation; the next frame's gains reflect only pixels after the ignored edge; i_enable = 0 at vs rise -> no o_gain_valid, gains held.
- i_rst pulsed during DIV_B -> gains = 256, o_busy = 0, no o_gain_valid pulse.
- With AWB_SAT_EXCLUDE_EN: half the lanes R=255,G=100,B=100 and half R=50,G=100,B=100 -> o_red_gain = 512. Without the macro -> o_red_gain = floor(25600/152.5) = 167 (sum-based).

Source files
------------

// File: rtl/awb_gain_calc.sv
// Gray-world AWB: per-frame RGB sums, serial restoring divide for R/B gains relative to G.
// Optional build macro AWB_SAT_EXCLUDE_EN drops lanes with any saturated component from the sums.
`timescale 1ns/1ps
module awb_gain_calc #(
   parameter int SUBPIXEL_WIDTH = 8,
   parameter int PIXEL_CNT      = 2,
   parameter int ACC_WIDTH      = 32
) (
   input  logic                                i_pclk,
   input  logic                                i_rst,
   input  logic                                i_enable,
   input  logic                                i_vs,
   input  logic                                i_de,
   input  logic                                i_valid,
   input  logic [SUBPIXEL_WIDTH*PIXEL_CNT-1:0] i_r,
   input  logic [SUBPIXEL_WIDTH*PIXEL_CNT-1:0] i_g,
   input  logic [SUBPIXEL_WIDTH*PIXEL_CNT-1:0] i_b,
   output logic [9:0]                          o_red_gain,
   output logic [9:0]                          o_green_gain,
   output logic [9:0]                          o_blue_gain,
   output logic                                o_gain_valid,
   output logic                                o_busy
);

   localparam int REM_W = ACC_WIDTH + 18;

   typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

   function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
      logic [ACC_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
   endfunction

   // Degenerate operands override the shifted-in quotient.
   function automatic logic [9:0] div_result(input logic [ACC_WIDTH-1:0] num_g,
                                             input logic [ACC_WIDTH-1:0] den,
                                             input logic [9:0]           quo);
      if (den == '0 || num_g == '0) return 10'd256;
      if ((REM_W'(num_g) << 8) >= (REM_W'(den) << 10)) return 10'd1023;
      return quo;
   endfunction

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d, idx;
   logic [REM_W-1:0]      rem_q, rem_d, rem_nx, den_sh;
   logic [ACC_WIDTH-1:0]  den_q, den_d;
   logic [9:0]            quo_q, quo_d, quo_nx, qr_q, qr_d;
   logic [ACC_WIDTH-1:0]  acc_r_q, acc_g_q, acc_b_q, acc_r_d, acc_g_d, acc_b_d;
   logic [ACC_WIDTH-1:0]  sum_r_q, sum_g_q, sum_b_q, sum_r_d, sum_g_d, sum_b_d;
   logic [ACC_WIDTH-1:0]  lsum_r, lsum_g, lsum_b;
   logic [SUBPIXEL_WIDTH-1:0] lr, lg, lb;
   logic                  keep, qual, frame_edge, take;
   logic                  vs_q, busy_q, valid_q, valid_d;
   logic [9:0]            red_q, red_d, blue_q, blue_d;

   assign qual       = i_de && i_valid;
   assign frame_edge = i_vs && !vs_q;

   always_comb begin
      lsum_r = '0;
      lsum_g = '0;
      lsum_b = '0;
      lr     = '0;
      lg     = '0;
      lb     = '0;
      keep   = 1'b1;
      for (int k = 0; k < PIXEL_CNT; k++) begin
         lr = i_r[k*SUBPIXEL_WIDTH +: SUBPIXEL_WIDTH];
         lg = i_g[k*SUBPIXEL_WIDTH +: SUBPIXEL_WIDTH];
         lb = i_b[k*SUBPIXEL_WIDTH +: SUBPIXEL_WIDTH];
`ifdef AWB_SAT_EXCLUDE_EN
         keep = ~(&lr | &lg | &lb);
`else
         keep = 1'b1;
`endif
         if (keep) begin
            lsum_r = lsum_r + ACC_WIDTH'(lr);
            lsum_g = lsum_g + ACC_WIDTH'(lg);
            lsum_b = lsum_b + ACC_WIDTH'(lb);
         end
      end
   end

   always_comb begin
      acc_r_d = acc_r_q;
      acc_g_d = acc_g_q;
      acc_b_d = acc_b_q;
      if (frame_edge) begin
         acc_r_d = qual ? lsum_r : '0;
         acc_g_d = qual ? lsum_g : '0;
         acc_b_d = qual ? lsum_b : '0;
      end else if (qual) begin
         acc_r_d = sat_add(acc_r_q, lsum_r);
         acc_g_d = sat_add(acc_g_q, lsum_g);
         acc_b_d = sat_add(acc_b_q, lsum_b);
      end
   end

   // One restoring step: quotient bit 9 - cnt.
   always_comb begin
      idx    = 4'd9 - cnt_q;
      den_sh = REM_W'(den_q) << idx;
      take   = rem_q >= den_sh;
      rem_nx = take ? rem_q - den_sh : rem_q;
      quo_nx = {quo_q[8:0], take};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      den_d   = den_q;
      quo_d   = quo_q;
      qr_d    = qr_q;
      sum_r_d = sum_r_q;
      sum_g_d = sum_g_q;
      sum_b_d = sum_b_q;
      red_d   = red_q;
      blue_d  = blue_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_edge && i_enable) begin
               sum_r_d = acc_r_q;
               sum_g_d = acc_g_q;
               sum_b_d = acc_b_q;
               rem_d   = REM_W'(acc_g_q) << 8;
               den_d   = acc_r_q;
               cnt_d   = '0;
               quo_d   = '0;
               state_d = DIV_R;
            end
         end
         DIV_R: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               qr_d    = div_result(sum_g_q, sum_r_q, quo_nx);
               rem_d   = REM_W'(sum_g_q) << 8;
               den_d   = sum_b_q;
               quo_d   = '0;
               cnt_d   = '0;
               state_d = DIV_B;
            end
         end
         DIV_B: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               quo_d   = div_result(sum_g_q, sum_b_q, quo_nx);
               cnt_d   = '0;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            red_d   = qr_q;
            blue_d  = quo_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         den_q   <= '0;
         quo_q   <= '0;
         qr_q    <= '0;
         acc_r_q <= '0;
         acc_g_q <= '0;
         acc_b_q <= '0;
         sum_r_q <= '0;
         sum_g_q <= '0;
         sum_b_q <= '0;
         vs_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         red_q   <= 10'd256;
         blue_q  <= 10'd256;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         den_q   <= den_d;
         quo_q   <= quo_d;
         qr_q    <= qr_d;
         acc_r_q <= acc_r_d;
         acc_g_q <= acc_g_d;
         acc_b_q <= acc_b_d;
         sum_r_q <= sum_r_d;
         sum_g_q <= sum_g_d;
         sum_b_q <= sum_b_d;
         vs_q    <= i_vs;
         busy_q  <= (state_q != IDLE);
         valid_q <= valid_d;
         red_q   <= red_d;
         blue_q  <= blue_d;
      end
   end

   assign o_red_gain   = red_q;
   assign o_green_gain = 10'd256;
   assign o_blue_gain  = blue_q;
   assign o_gain_valid = valid_q;
   assign o_busy       = busy_q;

endmodule
